// File: rtl/alu_pkg.sv
// Shared constants for the registered integer ALU: operand width, op-select width
// and the bit position of each operation in the one-hot select.
package alu_pkg;

  localparam int XLEN = 32;
  localparam int NOPS = 13;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_AND  = 2;
  localparam int OP_OR   = 3;
  localparam int OP_XOR  = 4;
  localparam int OP_SLL  = 5;
  localparam int OP_SRL  = 6;
  localparam int OP_SRA  = 7;
  localparam int OP_SLT  = 8;
  localparam int OP_SLTU = 9;
  localparam int OP_MUL  = 10;
  localparam int OP_MULU = 11;
  localparam int OP_PASS = 12;

  // True when more than one select bit is set; clearing the lowest set bit leaves a remainder.
  function automatic logic multi_hot(input logic [NOPS-1:0] v);
    return |(v & (v - NOPS'(1)));
  endfunction

endpackage

// File: rtl/alu_mul.sv
// Combinational 32x32->64 multiplier giving both the signed and unsigned product.
// Only compiled when ALU_MUL_EN is defined, since the ALU instantiates it only then.
`ifdef ALU_MUL_EN
module alu_mul
  import alu_pkg::*;
(
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] prod_s_o,
  output logic [2*XLEN-1:0] prod_u_o
);

  logic signed [2*XLEN-1:0] a_sx;
  logic signed [2*XLEN-1:0] b_sx;
  logic        [2*XLEN-1:0] a_zx;
  logic        [2*XLEN-1:0] b_zx;

  // Extending to full width first keeps the low 64 bits of the product exact.
  assign a_sx = $signed({{XLEN{a_i[XLEN-1]}}, a_i});
  assign b_sx = $signed({{XLEN{b_i[XLEN-1]}}, b_i});
  assign a_zx = {{XLEN{1'b0}}, a_i};
  assign b_zx = {{XLEN{1'b0}}, b_i};

  assign prod_s_o = $unsigned(a_sx * b_sx);
  assign prod_u_o = a_zx * b_zx;

endmodule
`endif

// File: rtl/alu.sv
// Single-cycle registered 32-bit ALU with one-hot op select and 64-bit result.
// Define ALU_MUL_EN to build the MUL/MULU ops; otherwise they report illegal.
module alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   in1,
  input  logic [XLEN-1:0]   in2,
  input  logic [NOPS-1:0]   instructions,
  output logic [2*XLEN-1:0] ALUoutput,
  output logic              illegal
);

  logic [2*XLEN-1:0] res_d, res_q;
  logic              ill_d, ill_q;
  logic [XLEN-1:0]   r32;
  logic [4:0]        shamt;
  logic              mul_bad;

  assign shamt = in2[4:0];

`ifdef ALU_MUL_EN
  logic [2*XLEN-1:0] prod_s;
  logic [2*XLEN-1:0] prod_u;

  alu_mul u_mul (
    .a_i      (in1),
    .b_i      (in2),
    .prod_s_o (prod_s),
    .prod_u_o (prod_u)
  );

  assign mul_bad = 1'b0;
`else
  assign mul_bad = instructions[OP_MUL] | instructions[OP_MULU];
`endif

  always_comb begin
    r32   = '0;
    res_d = '0;
    ill_d = multi_hot(instructions) | mul_bad;
    if (!ill_d) begin
      // Select is at most one-hot here, so the first matching item is the only one.
      case (1'b1)
        instructions[OP_ADD]:  r32 = in1 + in2;
        instructions[OP_SUB]:  r32 = in1 - in2;
        instructions[OP_AND]:  r32 = in1 & in2;
        instructions[OP_OR]:   r32 = in1 | in2;
        instructions[OP_XOR]:  r32 = in1 ^ in2;
        instructions[OP_SLL]:  r32 = in1 << shamt;
        instructions[OP_SRL]:  r32 = in1 >> shamt;
        instructions[OP_SRA]:  r32 = $unsigned($signed(in1) >>> shamt);
        instructions[OP_SLT]:  r32 = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
        instructions[OP_SLTU]: r32 = {{(XLEN-1){1'b0}}, (in1 < in2)};
        instructions[OP_PASS]: r32 = in2;
        default:               r32 = '0;
      endcase
      res_d = {{XLEN{1'b0}}, r32};
`ifdef ALU_MUL_EN
      if (instructions[OP_MUL])  res_d = prod_s;
      if (instructions[OP_MULU]) res_d = prod_u;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      ill_q <= 1'b0;
    end else begin
      res_q <= res_d;
      ill_q <= ill_d;
    end
  end

  assign ALUoutput = res_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the registered ALU; MUL expectations follow ALU_MUL_EN.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [12:0] instructions;
  logic [63:0] ALUoutput;
  logic        illegal;

  int n_cmp;
  int n_bad;

  alu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in1          (in1),
    .in2          (in2),
    .instructions (instructions),
    .ALUoutput    (ALUoutput),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Drive between edges, let one posedge register the result, sample 1 ns later.
  task automatic run_op(input string tag, input int op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input logic exp_ill);
    logic [12:0] sel;
    sel = 13'h1 << op;
    @(negedge clk);
    in1 = a; in2 = b; instructions = sel;
    @(posedge clk); #1;
    chk(tag, ALUoutput, exp);
    chk({tag, ".ill"}, {63'b0, illegal}, {63'b0, exp_ill});
  endtask

  task automatic run_raw(input string tag, input logic [12:0] sel, input logic [63:0] exp,
                         input logic exp_ill);
    @(negedge clk);
    in1 = 32'h5; in2 = 32'h4; instructions = sel;
    @(posedge clk); #1;
    chk(tag, ALUoutput, exp);
    chk({tag, ".ill"}, {63'b0, illegal}, {63'b0, exp_ill});
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; in1 = 32'h5; in2 = 32'h4; instructions = 13'h1;
    #12;
    chk("rst.out", ALUoutput, 64'h0);
    chk("rst.ill", {63'b0, illegal}, 64'h0);
    @(negedge clk); rst_n = 1'b1;

    run_op("add",  0, 32'd5, 32'd4, 64'd9,  1'b0);
    run_op("sub",  1, 32'd5, 32'd4, 64'd1,  1'b0);
    run_op("and",  2, 32'd5, 32'd4, 64'd4,  1'b0);
    run_op("or",   3, 32'd5, 32'd4, 64'd5,  1'b0);
    run_op("xor",  4, 32'd5, 32'd4, 64'd1,  1'b0);
    run_op("sll",  5, 32'd5, 32'd4, 64'd80, 1'b0);
    run_op("srl",  6, 32'd5, 32'd4, 64'd0,  1'b0);
    run_op("sra",  7, 32'd5, 32'd4, 64'd0,  1'b0);
    run_op("slt",  8, 32'd5, 32'd4, 64'd0,  1'b0);
    run_op("sltu", 9, 32'd5, 32'd4, 64'd0,  1'b0);

    run_op("sra.neg",  7, 32'h8000_0000, 32'd1, 64'h0000_0000_C000_0000, 1'b0);
    run_op("srl.neg",  6, 32'h8000_0000, 32'd1, 64'h0000_0000_4000_0000, 1'b0);
    run_op("slt.neg",  8, 32'h8000_0000, 32'd0, 64'd1, 1'b0);
    run_op("sltu.big", 9, 32'h8000_0000, 32'd0, 64'd0, 1'b0);
    run_op("sub.wrap", 1, 32'd4, 32'd5, 64'h0000_0000_FFFF_FFFF, 1'b0);
    run_op("add.wrap", 0, 32'hFFFF_FFFF, 32'd1, 64'd0, 1'b0);
    run_op("sll.amt",  5, 32'd1, 32'd33, 64'd2, 1'b0);
    run_op("slt.pos",  8, 32'd3, 32'd7, 64'd1, 1'b0);
    run_op("pass",    12, 32'hDEAD_BEEF, 32'h0000_1234, 64'h1234, 1'b0);

`ifdef ALU_MUL_EN
    run_op("mul",  10, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    run_op("mulu", 11, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 1'b0);
`else
    run_op("mul",  10, 32'hFFFF_FFFF, 32'd2, 64'd0, 1'b1);
    run_op("mulu", 11, 32'hFFFF_FFFF, 32'd2, 64'd0, 1'b1);
`endif

    run_raw("nop",   13'h0,    64'd0, 1'b0);
    run_raw("multi", 13'h3,    64'd0, 1'b1);
    run_raw("multi2", 13'h1010, 64'd0, 1'b1);

    // Leave a nonzero result registered, then reset between edges.
    run_op("pre_rst", 0, 32'd5, 32'd4, 64'd9, 1'b0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst.out", ALUoutput, 64'd0);
    @(posedge clk); #1;
    chk("held_rst.out", ALUoutput, 64'd0);
    run_raw("pre_rst_ill", 13'h3, 64'd0, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    in1 = 32'd5; in2 = 32'd4; instructions = 13'h1;
    @(posedge clk); #1;
    chk("post_rst.out", ALUoutput, 64'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
